tdpram32_bus_responder: RTL and testbench

- Bus-side responder that drives the 32-bit port of the simulation dual-port RAM (we/rd/byte_en/addr/wdata, 1-cycle registered read data) from a valid/ready request channel.
- Accepts single-beat writes and 1/2/4/8-beat incrementing or wrapping read bursts.
- Returns read data through a credit-managed response FIFO, so RAM reads are never lost under rsp_ready backpressure.
- Sits between the BA22 testbench data-bus master and the RAM.

---
 rtl/tdpram32_bus_responder_pkg.sv | 25 ++
 rtl/tdpram_rsp_fifo.sv | 54 +++++
 rtl/tdpram32_bus_responder.sv | 148 ++++++++++++++
 tb/tb_tdpram32_bus_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdpram32_bus_responder_pkg.sv
// Shared types for the dual-port RAM bus responder: burst length codes and
// the sequencer state encoding.
package tdpram32_bus_responder_pkg;

  localparam logic [1:0] LEN_1 = 2'd0;
  localparam logic [1:0] LEN_2 = 2'd1;
  localparam logic [1:0] LEN_4 = 2'd2;
  localparam logic [1:0] LEN_8 = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RBURST = 1'b1
  } state_t;

  function automatic logic [3:0] beats_of(input logic [1:0] len);
    beats_of = 4'd1;
    case (len)
      LEN_1: beats_of = 4'd1;
      LEN_2: beats_of = 4'd2;
      LEN_4: beats_of = 4'd4;
      LEN_8: beats_of = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/tdpram_rsp_fifo.sv
// Read-response FIFO: registered storage, head word visible combinationally,
// occupancy exported so the sequencer can issue reads against free credit.
module tdpram_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Credit accounting upstream must make this unreachable.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop && count == CW'(DEPTH)));
`endif

endmodule

// File: rtl/tdpram32_bus_responder.sv
// Valid/ready request front end for the 32-bit RAM port: single writes and
// 1/2/4/8-beat incr/wrap read bursts, reads throttled by response credit.
//   state     | meaning
//   ST_IDLE   | accepting requests; writes and beat 0 of reads issue here
//   ST_RBURST | issuing remaining read beats whenever a credit is free
module tdpram32_bus_responder
  import tdpram32_bus_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+2:0] req_addr,
  input  logic [3:0]            req_be,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_len,
  input  logic                  req_wrap,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_last,
  output logic                  ram_we,
  output logic                  ram_rd,
  output logic [3:0]            ram_byte_en,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);
  localparam int WAW = ADDR_WIDTH + 1;
  localparam int CW  = $clog2(RSP_DEPTH) + 1;
  localparam int OW  = CW + 1;

  state_t          state, state_nxt;
  logic [WAW-1:0]  addr_q, addr_nxt;
  logic [WAW-1:0]  mask_q, mask_nxt;
  logic [2:0]      rem_q, rem_nxt;
  logic            inflight, inflight_last, issue_last;
  logic [CW-1:0]   fifo_count;
  logic [OW-1:0]   occupancy;
  logic            free, fifo_empty;
  logic [32:0]     fifo_head;
  logic [WAW-1:0]  req_word, burst_mask;
  logic [3:0]      req_beats;
  logic            unused_addr_lsb;

  // A single mask covers both modes: all-ones gives plain increment with
  // natural wrap at the top of memory, beats-1 confines the carry.
  function automatic logic [WAW-1:0] next_word(input logic [WAW-1:0] a,
                                               input logic [WAW-1:0] m);
    return (a & ~m) | ((a + WAW'(1)) & m);
  endfunction

  assign unused_addr_lsb = ^req_addr[1:0];
  assign req_word   = req_addr[ADDR_WIDTH+2:2];
  assign req_beats  = beats_of(req_len);
  assign burst_mask = req_wrap ? WAW'(req_beats - 4'd1) : '1;
  assign occupancy  = OW'(fifo_count) + OW'(inflight);
  assign free       = occupancy < OW'(RSP_DEPTH);
  assign ram_wdata  = req_wdata;

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    mask_nxt    = mask_q;
    rem_nxt     = rem_q;
    req_ready   = 1'b0;
    ram_we      = 1'b0;
    ram_rd      = 1'b0;
    ram_byte_en = 4'hF;
    ram_addr    = addr_q;
    issue_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = free && rst_n;
        ram_addr  = req_word;
        if (req_we) ram_byte_en = req_be;
        if (req_valid && req_ready) begin
          if (req_we) begin
            ram_we = 1'b1;
          end else begin
            ram_rd = 1'b1;
            if (req_beats == 4'd1) begin
              issue_last = 1'b1;
            end else begin
              addr_nxt  = next_word(req_word, burst_mask);
              mask_nxt  = burst_mask;
              rem_nxt   = 3'(req_beats - 4'd1);
              state_nxt = ST_RBURST;
            end
          end
        end
      end
      ST_RBURST: begin
        if (free) begin
          ram_rd   = 1'b1;
          addr_nxt = next_word(addr_q, mask_q);
          rem_nxt  = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            issue_last = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      mask_q        <= '0;
      rem_q         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr_q        <= addr_nxt;
      mask_q        <= mask_nxt;
      rem_q         <= rem_nxt;
      inflight      <= ram_rd;
      inflight_last <= issue_last;
    end
  end

  tdpram_rsp_fifo #(
    .WIDTH (33),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_last, ram_rdata}),
    .pop       (rsp_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_rdata = rsp_valid ? fifo_head[31:0] : 32'h0;
  assign rsp_last  = rsp_valid && fifo_head[32];

endmodule

// File: tb/tb_tdpram32_bus_responder.sv
// Directed bench for tdpram32_bus_responder with a behavioural 1-cycle RAM.
module tb_tdpram32_bus_responder;
  localparam int AW = 13;
  localparam int NW = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_wrap;
  logic [AW+2:0] req_addr;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic [1:0]    req_len;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [31:0]   rsp_rdata;
  logic          ram_we, ram_rd;
  logic [3:0]    ram_byte_en;
  logic [AW:0]   ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [NW];
  logic [31:0] rd_log[$];
  int          rd_cyc[$];
  logic [31:0] rsp_q[$];
  logic        last_q[$];

  logic        acc_we, acc_rd;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_be;

  always #5 clk = ~clk;

  tdpram32_bus_responder #(.ADDR_WIDTH(AW), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .req_len(req_len), .req_wrap(req_wrap),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last),
    .ram_we(ram_we), .ram_rd(ram_rd), .ram_byte_en(ram_byte_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_byte_en[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_rd) begin
      rd_log.push_back(32'(ram_addr));
      rd_cyc.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) begin
      rsp_q.push_back(rsp_rdata);
      last_q.push_back(rsp_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    rd_cyc.delete();
    rsp_q.delete();
    last_q.delete();
  endtask

  task automatic do_req(input logic we, input logic [AW+2:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [1:0] len, input logic wrap);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be;
    req_wdata = wd; req_len = len; req_wrap = wrap;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        acc_we = ram_we; acc_rd = ram_rd; acc_addr = 32'(ram_addr);
        acc_be = ram_byte_en; acc_wdata = ram_wdata;
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    req_valid = 1'b0;
    chk("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 100 && rsp_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
    chk("rsp_count", 32'(rsp_q.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_a [8];
    logic [31:0] exp_d [8];
    logic [7:0]  lasts;

    for (int i = 0; i < NW; i++) mem[i] = 32'hD000_0000 | 32'(i);
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_be = 4'h0;
    req_wdata = '0; req_len = 2'd0; req_wrap = 1'b0; rsp_ready = 1'b1;

    // Reset state with a read request already pending
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_last",  32'(rsp_last),  32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_ram_rd",    32'(ram_rd),    32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Full-word write then single read of the same word
    do_req(1'b1, 16'h0010, 4'hF, 32'hA5A5_0001, 2'd0, 1'b0);
    chk("wr_ram_we",    32'(acc_we), 32'd1);
    chk("wr_ram_addr",  acc_addr,    32'd4);
    chk("wr_byte_en",   32'(acc_be), 32'hF);
    chk("wr_wdata",     acc_wdata,   32'hA5A5_0001);
    do_req(1'b0, 16'h0010, 4'h0, 32'h0, 2'd0, 1'b0);
    chk("rd1_ram_rd",   32'(acc_rd), 32'd1);
    chk("rd1_ram_addr", acc_addr,    32'd4);
    @(negedge clk);
    chk("rd1_valid_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd1_valid", 32'(rsp_valid), 32'd1);
    chk("rd1_rdata", rsp_rdata,      32'hA5A5_0001);
    chk("rd1_last",  32'(rsp_last),  32'd1);
    @(posedge clk); #1;

    // 4-beat wrapping read starting at word 6
    clear_logs();
    do_req(1'b0, 16'h0018, 4'h0, 32'h0, 2'd2, 1'b1);
    wait_rsp(4);
    exp_a[0:3] = '{32'd6, 32'd7, 32'd4, 32'd5};
    exp_d[0:3] = '{32'hD000_0006, 32'hD000_0007, 32'hA5A5_0001, 32'hD000_0005};
    lasts = '0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_addr%0d", i), rd_log[i], exp_a[i]);
      chk($sformatf("wrap_data%0d", i), rsp_q[i], exp_d[i]);
      lasts[i] = last_q[i];
    end
    chk("wrap_last", 32'(lasts), 32'h08);

    // 8-beat incrementing read across the top of memory
    clear_logs();
    do_req(1'b0, 16'hFFF8, 4'h0, 32'h0, 2'd3, 1'b0);
    wait_rsp(8);
    exp_a = '{32'd16382, 32'd16383, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    exp_d = '{32'hD000_3FFE, 32'hD000_3FFF, 32'hD000_0000, 32'hD000_0001,
              32'hD000_0002, 32'hD000_0003, 32'hA5A5_0001, 32'hD000_0005};
    lasts = '0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("top_addr%0d", i), rd_log[i], exp_a[i]);
      chk($sformatf("top_data%0d", i), rsp_q[i], exp_d[i]);
      lasts[i] = last_q[i];
    end
    chk("top_last", 32'(lasts), 32'h80);
    chk("top_rd_consecutive", 32'(rd_cyc[7] - rd_cyc[0]), 32'd7);

    // Backpressure: credit limits issue to the FIFO depth
    clear_logs();
    rsp_ready = 1'b0;
    do_req(1'b0, 16'h0080, 4'h0, 32'h0, 2'd3, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("bp_rd_pulses", 32'(rd_log.size()), 32'd4);
    chk("bp_rsp_valid", 32'(rsp_valid),     32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_rsp(8);
    chk("bp_rd_total", 32'(rd_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_addr%0d", i), rd_log[i], 32'h20 + 32'(i));
      chk($sformatf("bp_data%0d", i), rsp_q[i], 32'hD000_0020 + 32'(i));
    end

    // Partial write merge
    clear_logs();
    do_req(1'b1, 16'h0100, 4'hF,    32'hFFFF_FFFF, 2'd0, 1'b0);
    do_req(1'b1, 16'h0100, 4'b0101, 32'h1122_3344, 2'd0, 1'b0);
    chk("pw_byte_en", 32'(acc_be), 32'h5);
    do_req(1'b0, 16'h0100, 4'h0, 32'h0, 2'd0, 1'b0);
    wait_rsp(1);
    chk("pw_rdata", rsp_q[0], 32'hFF22_FF44);

    // Asynchronous reset while the 4th beat of an 8-beat read issues
    clear_logs();
    do_req(1'b0, 16'h00C0, 4'h0, 32'h0, 2'd3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ar_pre_ram_rd",    32'(ram_rd),    32'd1);
    chk("ar_pre_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ar_ram_rd",    32'(ram_rd),    32'd0);
    chk("ar_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    @(negedge clk);
    chk("ar_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    chk("ar_no_ghost_rsp", 32'(rsp_q.size()), 32'd0);
    chk("ar_no_ghost_rd",  32'(rd_log.size()), 32'd0);
    do_req(1'b0, 16'h00C0, 4'h0, 32'h0, 2'd0, 1'b0);
    wait_rsp(1);
    chk("ar_rdata", rsp_q[0], 32'hD000_0030);
    chk("ar_last",  32'(last_q[0]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
